bicubic_frame_buffer: RTL and testbench

Memory-side counterpart of the bicubic scaler. Loads a 100x100 8-bit source image from a byte stream, starts the scaler, and answers its source-read port with fixed one-cycle latency. It captures the scaler's result writes, then streams the TW x TH result frame back out. It sits between the host byte streams and the scaler's `iaddr`/`ird`/`we`/`waddr` ports.

---
 rtl/bicubic_frame_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_bicubic_frame_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_frame_buffer.sv
`timescale 1ns/1ps
// bicubic_frame_buffer
//   Memory-side partner of the bicubic scaler. It loads a 100x100 8-bit
//   source image from a byte stream and then enables the scaler. While the
//   scaler runs, this block serves its source reads with a fixed one-cycle
//   latency and captures its result writes. It then streams the TW x TH
//   result frame back out through a ready/valid port.
//
//   Optional feature: define BICUBIC_FB_CHK_EN to flag out-of-range scaler
//   accesses on the sticky `err` output. Without it, `err` is tied low.
//   Out-of-range writes are dropped and out-of-range reads return 0 in
//   both builds.
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   start, TW, TH       frame request (honoured only in IDLE) and target size
//   in_valid/in_ready/in_data      source image load stream
//   enable              scaler run enable (high in RUN)
//   iaddr, ird, input_data         scaler source read port (1-cycle latency)
//   we, waddr, output_data         scaler result write port
//   scl_done            scaler DONE level
//   out_valid/out_ready/out_data/out_last   result stream
//   busy                high in any state other than IDLE
//   err                 sticky range-error flag
module bicubic_frame_buffer #(
    parameter int SRC_DEPTH = 10000,
    parameter int DST_DEPTH = 4096
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [5:0]  TW,
    input  logic [5:0]  TH,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        enable,
    input  logic [13:0] iaddr,
    input  logic        ird,
    output logic [7:0]  input_data,
    input  logic        we,
    input  logic [13:0] waddr,
    input  logic [7:0]  output_data,
    input  logic        scl_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [13:0] SRC_LIM  = 14'(SRC_DEPTH);
    localparam logic [13:0] SRC_LAST = 14'(SRC_DEPTH - 1);

    state_t state_q, state_d;

    logic [7:0]  src_mem [SRC_DEPTH];
    logic [7:0]  dst_mem [DST_DEPTH];

    logic [11:0] prod_q;      // TW*TH, captured on an accepted start
    logic [13:0] lcnt_q;      // source load address
    logic [11:0] rd_idx_q;    // next result address to fetch in DRAIN

    // Drain pipeline: one registered RAM read in flight, then a 2-entry FIFO.
    logic        pend_q;
    logic        pend_last_q;
    logic [7:0]  dst_q;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [1:0][7:0] f_data_q, f_data_d;
    logic [1:0]  f_last_q, f_last_d;
    logic [1:0]  occ;

    logic start_ok, load_beat, load_last;
    logic wr_in_range, wr_ok, rd_in_range;
    logic pop, issue;

    assign start_ok    = (state_q == IDLE) && start;
    assign load_beat   = (state_q == LOAD) && in_valid;
    assign load_last   = load_beat && (lcnt_q == SRC_LAST);
    assign wr_in_range = waddr < {2'b00, prod_q};
    assign wr_ok       = (state_q == RUN) && we && wr_in_range;
    assign rd_in_range = iaddr < SRC_LIM;

    assign out_valid = (fcnt_q != 2'd0);
    assign out_data  = f_data_q[0];
    assign out_last  = out_valid && f_last_q[0];
    assign pop       = out_valid && out_ready;

    // Slots that will be occupied after this edge if no new read is issued.
    // A read is issued only when its result is guaranteed a FIFO slot, so
    // the FIFO can never overflow.
    assign occ   = fcnt_q + {1'b0, pend_q} - {1'b0, pop};
    assign issue = (state_q == DRAIN) && (rd_idx_q < prod_q) && (occ < 2'd2);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        enable   = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:  if (start) state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (load_last) state_d = RUN;
            end
            RUN: begin
                enable = 1'b1;
                if (scl_done) state_d = (prod_q == 12'd0) ? IDLE : DRAIN;
            end
            DRAIN: if (pop && f_last_q[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO next state: pop shifts entry 1 to the head, and a push lands in
    // the first free slot after the pop.
    always_comb begin
        f_data_d = f_data_q;
        f_last_d = f_last_q;
        fcnt_d   = fcnt_q;
        if (pop) begin
            f_data_d[0] = f_data_q[1];
            f_last_d[0] = f_last_q[1];
            fcnt_d      = fcnt_d - 2'd1;
        end
        if (pend_q) begin
            f_data_d[fcnt_d[0]] = dst_q;
            f_last_d[fcnt_d[0]] = pend_last_q;
            fcnt_d              = fcnt_d + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prod_q      <= '0;
            lcnt_q      <= '0;
            rd_idx_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            fcnt_q      <= '0;
            f_data_q    <= '0;
            f_last_q    <= '0;
            input_data  <= '0;
        end else begin
            if (start_ok) begin
                prod_q   <= 12'(TW) * 12'(TH);
                lcnt_q   <= '0;
                rd_idx_q <= '0;
            end
            if (load_beat) lcnt_q <= lcnt_q + 14'd1;

            pend_q <= issue;
            if (issue) begin
                pend_last_q <= (rd_idx_q == prod_q - 12'd1);
                rd_idx_q    <= rd_idx_q + 12'd1;
            end
            fcnt_q   <= fcnt_d;
            f_data_q <= f_data_d;
            f_last_q <= f_last_d;

            // Reads in the same cycle as a LOAD write return the old byte.
            if (ird) input_data <= rd_in_range ? src_mem[iaddr] : 8'h00;
        end
    end

    // NOTE: the RAM arrays have no reset; their contents survive reset and
    // they stay mappable onto block RAM.
    always_ff @(posedge CLK) begin
        if (load_beat) src_mem[lcnt_q] <= in_data;
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) dst_mem[waddr[11:0]] <= output_data;
        if (issue) dst_q <= dst_mem[rd_idx_q];
    end

`ifdef BICUBIC_FB_CHK_EN
    logic err_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            err_q <= 1'b0;
        else if (start_ok)
            err_q <= 1'b0;
        else if (((state_q == RUN) && we && !wr_in_range) || (ird && !rd_in_range))
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bicubic_frame_buffer.sv
`timescale 1ns/1ps
// Directed bench for bicubic_frame_buffer. Expected result bytes are queued
// when the scaler writes are driven and popped as the stream produces beats.
module tb_bicubic_frame_buffer;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [5:0]  TW, TH;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        enable;
    logic [13:0] iaddr;
    logic        ird;
    logic [7:0]  input_data;
    logic        we;
    logic [13:0] waddr;
    logic [7:0]  output_data;
    logic        scl_done;
    logic        out_valid, out_ready, out_last;
    logic [7:0]  out_data;
    logic        busy, err;

    int checks = 0;
    int errors = 0;

    logic [8:0] sb [$];          // {last, byte}
    logic [7:0] model [4096];
    int         prod_m;
    logic       exp_err;

    bicubic_frame_buffer dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .TW(TW), .TH(TH),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .enable(enable), .iaddr(iaddr), .ird(ird), .input_data(input_data),
        .we(we), .waddr(waddr), .output_data(output_data), .scl_done(scl_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [5:0] w, input logic [5:0] h);
        start = 1'b1; TW = w; TH = h;
        tick();
        start = 1'b0;
        prod_m = int'(w) * int'(h);
        check("start_in_ready", in_ready, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 10000; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k);
            if (k == 9999) check("enable_before_last_beat", enable, 0);
            tick();
        end
        in_valid = 1'b0;
        check("enable_after_last_beat", enable, 1);
        check("in_ready_after_load", in_ready, 0);
    endtask

    task automatic wr(input int addr, input logic [7:0] data, input logic done);
        we = 1'b1; waddr = 14'(addr); output_data = data; scl_done = done;
        if (addr < prod_m) model[addr] = data;
        tick();
        we = 1'b0; scl_done = 1'b0;
        if (done) begin
            for (int i = 0; i < prod_m; i++)
                sb.push_back({(i == prod_m - 1), model[i]});
        end
    endtask

    task automatic drain(input logic [7:0] pat, input int len, input int exp_beats);
        int c = 0;
        int beats = 0;
        int first = -1;
        logic stalled = 1'b0;
        logic done = 1'b0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        logic [8:0] e;
        while (!done && c < 200) begin
            out_ready = (c < len) ? pat[c] : 1'b1;
            @(negedge CLK);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, pd);
                check("stall_last", out_last, pl);
            end
            if (out_valid && first < 0) begin
                first = c;
                check("first_valid_latency", c, 2);
            end
            if (out_valid && out_ready) begin
                beats++;
                if (sb.size() == 0) begin
                    check("extra_beat", beats, exp_beats);
                end else begin
                    e = sb.pop_front();
                    check("drain_data", out_data, e[7:0]);
                    check("drain_last", out_last, e[8]);
                end
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (!busy) done = 1'b1;
            @(posedge CLK); #1;
            c++;
        end
        out_ready = 1'b0;
        check("drain_terminated", done, 1);
        check("drain_beats", beats, exp_beats);
        check("scoreboard_empty", sb.size(), 0);
        check("idle_out_valid", out_valid, 0);
    endtask

    task automatic frame_2x2(input logic [7:0] pat, input int len);
        do_start(6'd2, 6'd2);
        load_ramp();
        for (int i = 0; i < 4; i++) wr(i, 8'hA0 + 8'(i), 1'b0);
        wr(2, 8'h11, 1'b0);
        wr(3, 8'h22, 1'b1);
        check("enable_fall_after_done", enable, 0);
        check("busy_in_drain", busy, 1);
        drain(pat, len, 4);
    endtask

    initial begin
`ifdef BICUBIC_FB_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        RST_N = 1'b0; start = 1'b0; TW = '0; TH = '0;
        in_valid = 1'b0; in_data = '0; iaddr = '0; ird = 1'b0;
        we = 1'b0; waddr = '0; output_data = '0; scl_done = 1'b0; out_ready = 1'b0;
        prod_m = 0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        check("rst_input_data", input_data, 0);
        check("rst_out_data", out_data, 0);
        tick();

        // Reset in the middle of a load.
        do_start(6'd2, 6'd2);
        for (int k = 0; k < 500; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            tick();
        end
        RST_N = 1'b0;
        #1;
        check("midload_rst_in_ready", in_ready, 0);
        check("midload_rst_busy", busy, 0);
        in_valid = 1'b0;
        #2 RST_N = 1'b1;
        tick();

        // Full load, read-port latency, last-write-wins drain.
        do_start(6'd2, 6'd2);
        load_ramp();
        ird = 1'b1; iaddr = 14'd101;
        tick();
        check("read_101", input_data, 8'd101);
        iaddr = 14'd9999;
        tick();
        ird = 1'b0;
        check("read_9999", input_data, 8'd15);
        tick();
        check("read_hold", input_data, 8'd15);
        for (int i = 0; i < 4; i++) wr(i, 8'hA0 + 8'(i), 1'b0);
        wr(2, 8'h11, 1'b0);
        wr(3, 8'h22, 1'b1);
        check("enable_fall_after_done", enable, 0);
        drain(8'hFF, 8, 4);

        // Same frame with back-pressure 1,0,0,1,1.
        frame_2x2(8'b0001_1001, 5);

        // 3x3 frame with an out-of-range write and read.
        do_start(6'd3, 6'd3);
        load_ramp();
        for (int i = 0; i < 9; i++) wr(i, 8'h30 + 8'(i), 1'b0);
        wr(9, 8'hEE, 1'b0);
        check("err_after_bad_write", err, 32'(exp_err));
        ird = 1'b1; iaddr = 14'd5;
        tick();
        check("read_5", input_data, 8'd5);
        iaddr = 14'd10000;
        tick();
        ird = 1'b0;
        check("read_out_of_range", input_data, 8'd0);
        wr(0, 8'h30, 1'b1);
        drain(8'hFF, 8, 9);
        check("err_sticky", err, 32'(exp_err));

        // Zero-size frame; start during RUN is ignored.
        do_start(6'd0, 6'd5);
        check("err_cleared_by_start", err, 0);
        load_ramp();
        start = 1'b1; TW = 6'd4; TH = 6'd4;
        tick();
        start = 1'b0;
        check("start_in_run_enable", enable, 1);
        check("start_in_run_busy", busy, 1);
        scl_done = 1'b1;
        tick();
        scl_done = 1'b0;
        check("zero_frame_busy", busy, 0);
        check("zero_frame_enable", enable, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("zero_frame_no_valid", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
